tecla_cmd_fifo: RTL
===================

TECLA_CMD_FIFO -- requirements
Module: tecla_cmd_fifo

Interface
REQ-001 clk  in  1  system clock, 100 MHz.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 letra  in  8  make scancode from the keyboard receiver; valid while new_data=1.
REQ-004 new_data  in  1  level; high from scancode arrival until acknowledged.
REQ-005 new_data_pico  out  1  one-cycle acknowledge pulse to the keyboard receiver.
REQ-006 rd_en  in  1  consumer pop strobe (decoded PicoBlaze read of the command port).
REQ-007 cmd  out  8  command code at FIFO head (first-word fall-through); 0x00 when empty.
REQ-008 cmd_valid  out  1  FIFO not empty.
REQ-009 overflow  out  1  sticky; set when a mapped command is dropped because the FIFO is full.
REQ-010 clear_ovf  in  1  synchronous clear of overflow.

Function
REQ-011 FSM states: IDLE, DECODE, ACK, WAIT_LOW.
- IDLE -> DECODE when new_data=1.
- DECODE -> ACK, unconditionally after one cycle.
- ACK -> WAIT_LOW after one cycle.
- WAIT_LOW -> IDLE when new_data=0.
REQ-012 DECODE: letra is registered and mapped to a command.
- 0x2B->0x01 (format)
- 0x33->0x02 (hour)
- 0x2C->0x03 (timer)
- 0x75->0x10 (up)
- 0x72->0x11 (down)
- 0x6B->0x12 (left)
- 0x74->0x13 (right)
- 0x76->0x1F (ESC)
- any other code, including 0xF0 and 0xE0: unmapped.
REQ-013 DECODE push: a mapped code is pushed in the same cycle if the FIFO is not full or rd_en pops in that cycle; an unmapped code is discarded.
REQ-014 Full FIFO, mapped code, no pop: code dropped, overflow=1 next cycle; the ACK still occurs.
REQ-015 new_data_pico=1 exactly in the ACK cycle.
- Latency: new_data rise to new_data_pico = 2 cycles.
REQ-016 WAIT_LOW prevents double capture of one held new_data level.
REQ-017 FIFO: depth 4, width 8, FWFT.
- rd_en with cmd_valid=1 pops the head; rd_en when empty is ignored.
REQ-018 Simultaneous push and pop: both take effect, count unchanged, order preserved.
- Applies when full; when empty, the pushed word appears on cmd the next cycle.
REQ-019 Pointers are 2 bits and wrap 3->0; count is 3 bits, range 0..4.
REQ-020 clear_ovf together with a new overflow event: set wins.

Reset
REQ-021 While reset=0: FSM=IDLE, FIFO empty, pointers 0.
- Outputs: new_data_pico=0, cmd=0x00, cmd_valid=0, overflow=0.
REQ-022 Reset mid-handshake: returns to IDLE.
- If new_data is still high after release, the pending scancode is decoded afresh.

Configuration
REQ-023 Macro TECLA_DROP_CNT_EN defined: adds output drop_cnt [7:0].
- Counts discarded unmapped codes plus overflow drops.
- Saturates at 0xFF; reset to 0; cleared by clear_ovf.
REQ-024 Macro undefined: no drop_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-025 Package tecla_pkg holds scancode constants, command code constants, FIFO depth/width parameters and FSM state encoding.
REQ-026 One sub-module, tecla_fifo: 4x8 FWFT FIFO with push, pop, full, empty and count; the FSM and mapping stay in tecla_cmd_fifo.

Verification
REQ-027 Serial sequence F, H, T, up, right, left, down, ESC with rd_en held high -> cmd sequence 0x01, 0x02, 0x03, 0x10, 0x13, 0x12, 0x11, 0x1F; overflow=0.
REQ-028 Five mapped keys, rd_en=0 -> cmd_valid=1, count 4, fifth dropped, overflow=1; four pops yield the first four codes in order.
REQ-029 letra=0xF0 then 0x1C (unmapped) -> both acknowledged with one new_data_pico pulse each, cmd_valid stays 0; with TECLA_DROP_CNT_EN, drop_cnt=2.
REQ-030 new_data held high for 50 cycles with letra=0x2B -> exactly one push and one new_data_pico pulse, 2 cycles after the rise.
REQ-031 FIFO full plus mapped key arriving with rd_en=1 in the DECODE cycle -> no overflow, count stays 4, new code is at the tail.
REQ-032 reset=0 asserted in WAIT_LOW with 2 entries queued -> cmd_valid=0, cmd=0x00 immediately; after release with new_data=1, letra=0x76 -> cmd=0x1F.

Source files
------------

// File: rtl/tecla_pkg.sv
// Shared constants for the keyboard command FIFO: PS/2 make codes, command codes,
// FIFO geometry, handshake FSM states and the scancode-to-command mapping.
package tecla_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_W     = 8;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = 3'd4;

    localparam logic [7:0] SC_FORMAT = 8'h2B;
    localparam logic [7:0] SC_HOUR   = 8'h33;
    localparam logic [7:0] SC_TIMER  = 8'h2C;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    localparam logic [FIFO_W-1:0] CMD_NONE   = 8'h00;
    localparam logic [FIFO_W-1:0] CMD_FORMAT = 8'h01;
    localparam logic [FIFO_W-1:0] CMD_HOUR   = 8'h02;
    localparam logic [FIFO_W-1:0] CMD_TIMER  = 8'h03;
    localparam logic [FIFO_W-1:0] CMD_UP     = 8'h10;
    localparam logic [FIFO_W-1:0] CMD_DOWN   = 8'h11;
    localparam logic [FIFO_W-1:0] CMD_LEFT   = 8'h12;
    localparam logic [FIFO_W-1:0] CMD_RIGHT  = 8'h13;
    localparam logic [FIFO_W-1:0] CMD_ESC    = 8'h1F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ACK,
        ST_WAIT_LOW
    } state_t;

    typedef struct packed {
        logic              hit;
        logic [FIFO_W-1:0] code;
    } cmd_map_t;

    // Break (F0) and extended (E0) prefixes fall into the default branch.
    function automatic cmd_map_t map_scancode(input logic [7:0] sc);
        cmd_map_t m;
        m.hit  = 1'b1;
        m.code = CMD_NONE;
        case (sc)
            SC_FORMAT: m.code = CMD_FORMAT;
            SC_HOUR:   m.code = CMD_HOUR;
            SC_TIMER:  m.code = CMD_TIMER;
            SC_UP:     m.code = CMD_UP;
            SC_DOWN:   m.code = CMD_DOWN;
            SC_LEFT:   m.code = CMD_LEFT;
            SC_RIGHT:  m.code = CMD_RIGHT;
            SC_ESC:    m.code = CMD_ESC;
            default:   m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tecla_fifo.sv
// 4x8 first-word fall-through FIFO; push and pop in the same cycle both take
// effect, including when full.
module tecla_fifo
    import tecla_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [FIFO_W-1:0] din,
    output logic [FIFO_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [FIFO_W-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_ok;
    logic              push_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == FIFO_FULL_CNT);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop_ok   = pop && !empty;
        // A pop frees the slot the simultaneous push lands in when full.
        push_ok  = push && (!full || pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, push_ok} - {2'b00, pop_ok};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tecla_cmd_fifo.sv
// Keyboard scancode handshake, command mapping and command FIFO for PicoBlaze.
// Optional TECLA_DROP_CNT_EN adds a saturating drop_cnt of discarded codes.
module tecla_cmd_fifo
    import tecla_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        letra,
    input  logic              new_data,
    output logic              new_data_pico,
    input  logic              rd_en,
    output logic [FIFO_W-1:0] cmd,
    output logic              cmd_valid,
    output logic              overflow,
    input  logic              clear_ovf
`ifdef TECLA_DROP_CNT_EN
   ,output logic [7:0]        drop_cnt
`endif
);

    state_t            state_q, state_d;
    logic [7:0]        letra_q, letra_d;
    logic              overflow_q, overflow_d;
    cmd_map_t          map;
    logic              push;
    logic              ovf_drop;
    logic [FIFO_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    always_comb begin
        state_d  = state_q;
        letra_d  = letra_q;
        push     = 1'b0;
        ovf_drop = 1'b0;
        map      = map_scancode(letra_q);
        case (state_q)
            ST_IDLE: begin
                if (new_data) begin
                    letra_d = letra;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_ACK;
                if (map.hit) begin
                    if (!fifo_full || rd_en) begin
                        push = 1'b1;
                    end else begin
                        ovf_drop = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!new_data) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        overflow_d = ovf_drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            letra_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            letra_q    <= letra_d;
            overflow_q <= overflow_d;
        end
    end

    tecla_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .din   (map.code),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign new_data_pico = (state_q == ST_ACK);
    assign cmd           = fifo_empty ? CMD_NONE : fifo_dout;
    assign cmd_valid     = (fifo_count != '0);
    assign overflow      = overflow_q;

`ifdef TECLA_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop_event;

    // Every DECODE that does not push is either unmapped or an overflow drop.
    always_comb begin
        drop_event = (state_q == ST_DECODE) && !push;
        drop_cnt_d = drop_cnt_q;
        if (clear_ovf) begin
            drop_cnt_d = '0;
        end else if (drop_event && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
